ov9281_sccb_target: RTL and testbench

// - SCCB/I2C responder. It is the target end of the bus that the OV9281 config master drives.
// - Bridges SCCB transactions to a simple register-port handshake:
//   16-bit register address, 8-bit data, matching the OV9281 register map.
// - Used as the in-fabric sensor register model for config bring-up.
// - Also used as a host-visible register slave. Oversamples SCL/SDA on i_clk.

---
 rtl/ov9281_pkg.sv | 23 ++
 rtl/ov9281_sccb_target_line_cond.sv | 65 ++++++
 rtl/ov9281_sccb_target.sv | 183 ++++++++++++++++++
 tb/tb_ov9281_sccb_target.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov9281_pkg.sv
// Shared types for the OV9281 SCCB target and config master.
// Register map is 16-bit address, 8-bit data.
package ov9281_pkg;

   localparam int SCCB_ADDR_W = 16;
   localparam int SCCB_DATA_W = 8;

   typedef enum logic [3:0] {
      TGT_IDLE,
      TGT_DEV,
      TGT_DEV_ACK,
      TGT_AH,
      TGT_AH_ACK,
      TGT_AL,
      TGT_AL_ACK,
      TGT_WD,
      TGT_WD_ACK,
      TGT_RD,
      TGT_RD_ACK,
      TGT_IGNORE
   } sccb_tgt_state_t;

endpackage

// File: rtl/ov9281_sccb_target_line_cond.sv
// SCL/SDA conditioning: synchroniser, majority-free glitch filter (FILT_LEN equal samples),
// and single-cycle scl_rise/scl_fall/start/stop pulses.
module sccb_line_cond #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic [FILT_LEN-2:0]    scl_hist;
   logic [FILT_LEN-2:0]    sda_hist;
   logic [FILT_LEN-1:0]    scl_win;
   logic [FILT_LEN-1:0]    sda_win;
   logic                   scl;
   logic                   scl_prev;
   logic                   sda_prev;

   // The window includes the newest synchronised sample so the filter adds no extra stage.
   assign scl_win = {scl_hist, scl_sync[SYNC_STAGES-1]};
   assign sda_win = {sda_hist, sda_sync[SYNC_STAGES-1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_hist <= '1;
         sda_hist <= '1;
         scl      <= 1'b1;
         sda      <= 1'b1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_hist <= scl_win[FILT_LEN-2:0];
         sda_hist <= sda_win[FILT_LEN-2:0];
         if (&scl_win)
            scl <= 1'b1;
         else if (~|scl_win)
            scl <= 1'b0;
         if (&sda_win)
            sda <= 1'b1;
         else if (~|sda_win)
            sda <= 1'b0;
         scl_prev <= scl;
         sda_prev <= sda;
      end
   end

   assign scl_rise = scl & ~scl_prev;
   assign scl_fall = ~scl & scl_prev;
   assign start    = scl & scl_prev & sda_prev & ~sda;
   assign stop     = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/ov9281_sccb_target.sv
// SCCB/I2C target bridging bus transactions to a register-port handshake with
// an auto-incrementing 16-bit register pointer.
module ov9281_sccb_target
   import ov9281_pkg::*;
#(
   parameter int         CLK_SPEED   = 50000000,
   parameter logic [6:0] DEV_ADDR    = 7'h60,
   parameter int         SYNC_STAGES = 2,
   parameter int         FILT_LEN    = 3
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_scl_in,
   input  logic                   i_sda_in,
   output logic                   o_sda_out,
   output logic                   o_sda_oe,
   output logic [SCCB_ADDR_W-1:0] o_reg_addr,
   output logic [SCCB_DATA_W-1:0] o_reg_wdata,
   output logic                   o_reg_we,
   output logic                   o_reg_re,
   input  logic [SCCB_DATA_W-1:0] i_reg_rdata,
   output logic                   o_busy
);

   if (CLK_SPEED < 1 || SYNC_STAGES < 2 || FILT_LEN < 2) begin : g_bad_params
      $error("ov9281_sccb_target: invalid parameter value");
   end

   sccb_tgt_state_t        state, state_next;
   logic [3:0]             bit_cnt;
   logic [SCCB_DATA_W-1:0] shift, rd_shift, addr_hi, cur_byte;
   logic [SCCB_ADDR_W-1:0] addr;
   logic                   rw, re_d, dev_match;
   logic                   sda_f, scl_rise, scl_fall, start, stop;

   sccb_line_cond #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_line_cond (
      .clk      (i_clk),
      .rst      (i_rst),
      .scl_in   (i_scl_in),
      .sda_in   (i_sda_in),
      .sda      (sda_f),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   assign cur_byte   = {shift[6:0], sda_f};
   assign dev_match  = (shift[6:0] == DEV_ADDR);
   assign o_sda_out  = 1'b0;
   assign o_reg_addr = addr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         state <= TGT_IDLE;
      else
         state <= state_next;
   end

   // ACK states leave on the second SCL fall, recognised by bit_cnt already cleared to 0.
   always_comb begin
      state_next = state;
      if (stop)
         state_next = TGT_IDLE;
      else if (start)
         state_next = TGT_DEV;
      else begin
         case (state)
            TGT_DEV:     if (scl_rise && bit_cnt == 4'd7) state_next = dev_match ? TGT_DEV_ACK : TGT_IGNORE;
            TGT_AH:      if (scl_rise && bit_cnt == 4'd7) state_next = TGT_AH_ACK;
            TGT_AL:      if (scl_rise && bit_cnt == 4'd7) state_next = TGT_AL_ACK;
            TGT_WD:      if (scl_rise && bit_cnt == 4'd7) state_next = TGT_WD_ACK;
            TGT_DEV_ACK: if (scl_fall && bit_cnt == 4'd0) state_next = rw ? TGT_RD : TGT_AH;
            TGT_AH_ACK:  if (scl_fall && bit_cnt == 4'd0) state_next = TGT_AL;
            TGT_AL_ACK:  if (scl_fall && bit_cnt == 4'd0) state_next = TGT_WD;
            TGT_WD_ACK:  if (scl_fall && bit_cnt == 4'd0) state_next = TGT_WD;
            TGT_RD:      if (scl_fall && bit_cnt == 4'd8) state_next = TGT_RD_ACK;
            TGT_RD_ACK: begin
               if (scl_rise && sda_f)
                  state_next = TGT_IGNORE;
               else if (scl_fall)
                  state_next = TGT_RD;
            end
            default: ;
         endcase
      end
   end

   // Sampling happens on filtered SCL rises; every SDA drive change waits for a filtered SCL fall.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         bit_cnt     <= '0;
         shift       <= '0;
         rd_shift    <= '0;
         addr_hi     <= '0;
         addr        <= '0;
         rw          <= 1'b0;
         re_d        <= 1'b0;
         o_sda_oe    <= 1'b0;
         o_reg_we    <= 1'b0;
         o_reg_re    <= 1'b0;
         o_reg_wdata <= '0;
         o_busy      <= 1'b0;
      end else begin
         o_reg_we <= 1'b0;
         o_reg_re <= 1'b0;
         re_d     <= o_reg_re;
         if (re_d)
            rd_shift <= i_reg_rdata;
         if (stop) begin
            o_sda_oe <= 1'b0;
            o_busy   <= 1'b0;
         end else if (start) begin
            o_sda_oe <= 1'b0;
            bit_cnt  <= '0;
         end else if (scl_rise) begin
            case (state)
               TGT_DEV, TGT_AH, TGT_AL, TGT_WD: begin
                  shift   <= cur_byte;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     case (state)
                        TGT_DEV: begin
                           if (dev_match) begin
                              o_busy   <= 1'b1;
                              rw       <= sda_f;
                              o_reg_re <= sda_f;
                           end else
                              o_busy <= 1'b0;
                        end
                        TGT_AH:  addr_hi <= cur_byte;
                        TGT_AL:  addr    <= {addr_hi, cur_byte};
                        default: begin
                           o_reg_we    <= 1'b1;
                           o_reg_wdata <= cur_byte;
                        end
                     endcase
                  end
               end
               TGT_RD:     bit_cnt <= bit_cnt + 4'd1;
               TGT_WD_ACK: addr    <= addr + SCCB_ADDR_W'(1);
               TGT_RD_ACK: begin
                  addr     <= addr + SCCB_ADDR_W'(1);
                  o_reg_re <= ~sda_f;
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state)
               TGT_DEV_ACK, TGT_AH_ACK, TGT_AL_ACK, TGT_WD_ACK: begin
                  bit_cnt <= '0;
                  if (bit_cnt == 4'd8)
                     o_sda_oe <= 1'b1;
                  else if (state == TGT_DEV_ACK && rw) begin
                     o_sda_oe <= ~rd_shift[7];
                     rd_shift <= {rd_shift[6:0], 1'b0};
                  end else
                     o_sda_oe <= 1'b0;
               end
               TGT_RD: begin
                  if (bit_cnt == 4'd8) begin
                     o_sda_oe <= 1'b0;
                     bit_cnt  <= '0;
                  end else begin
                     o_sda_oe <= ~rd_shift[7];
                     rd_shift <= {rd_shift[6:0], 1'b0};
                  end
               end
               TGT_RD_ACK: begin
                  o_sda_oe <= ~rd_shift[7];
                  rd_shift <= {rd_shift[6:0], 1'b0};
                  bit_cnt  <= '0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ov9281_sccb_target.sv
// Directed bench for ov9281_sccb_target: a bit-banged SCCB master on open-drain lines
// plus a small register-read model and strobe logger.
module tb_ov9281_sccb_target;

   localparam int Q = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        scl_m;
   logic        sda_m;
   wire         sda_pad;
   logic        sda_out;
   logic        sda_oe;
   logic [15:0] reg_addr;
   logic [7:0]  reg_wdata;
   logic [7:0]  reg_rdata = 8'h00;
   logic        reg_we;
   logic        reg_re;
   logic        busy;

   int checks = 0;
   int errors = 0;

   int          we_cnt = 0, re_cnt = 0, oe_cyc = 0, both_cnt = 0;
   logic [15:0] we_addr_log [0:15];
   logic [7:0]  we_data_log [0:15];
   logic [15:0] re_addr_log [0:15];

   always #10 clk = ~clk;

   assign sda_pad = sda_m & ~sda_oe;

   ov9281_sccb_target dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_scl_in    (scl_m),
      .i_sda_in    (sda_pad),
      .o_sda_out   (sda_out),
      .o_sda_oe    (sda_oe),
      .o_reg_addr  (reg_addr),
      .o_reg_wdata (reg_wdata),
      .o_reg_we    (reg_we),
      .o_reg_re    (reg_re),
      .i_reg_rdata (reg_rdata),
      .o_busy      (busy)
   );

   function automatic logic [7:0] model_rd(input logic [15:0] a);
      case (a)
         16'h300A: model_rd = 8'hA5;
         16'h300B: model_rd = 8'h3C;
         default:  model_rd = 8'h00;
      endcase
   endfunction

   always @(posedge clk)
      if (reg_re)
         reg_rdata <= model_rd(reg_addr);

   // Strobe logger: counts only grow, so each test compares against a snapshot.
   always @(negedge clk) begin
      if (reg_we) begin
         we_addr_log[we_cnt[3:0]] = reg_addr;
         we_data_log[we_cnt[3:0]] = reg_wdata;
         we_cnt++;
      end
      if (reg_re) begin
         re_addr_log[re_cnt[3:0]] = reg_addr;
         re_cnt++;
      end
      if (sda_oe)
         oe_cyc++;
      if (reg_we && reg_re)
         both_cnt++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // One SCL period; optional 30 ns SDA glitch while SCL is high.
   task automatic applyStimulus(input logic b, input logic glitch, output logic s);
      sda_m = b;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(3);
      if (glitch) begin
         #7 sda_m = ~b;
         #30 sda_m = b;
      end
      wait_clk(Q - 3);
      s = sda_pad;
      wait_clk(Q);
      scl_m = 1'b0;
      wait_clk(Q);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(Q);
      sda_m = 1'b0;
      wait_clk(Q);
      scl_m = 1'b0;
      wait_clk(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(Q);
      sda_m = 1'b1;
      wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, input logic [7:0] gmask, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--)
         applyStimulus(d[i], gmask[i], s);
      applyStimulus(1'b1, 1'b0, ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(1'b1, 1'b0, s);
         d[i] = s;
      end
      applyStimulus(nack, 1'b0, s);
   endtask

   initial begin
      logic       ack, ack_or;
      logic [7:0] rd;
      int         we_base, re_base, oe_base;

      rst   = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      wait_clk(3);
      @(negedge clk);
      checkOutput("rst_oe", sda_oe, 0);
      checkOutput("rst_we", reg_we, 0);
      checkOutput("rst_re", reg_re, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_addr", reg_addr, 0);
      checkOutput("rst_wdata", reg_wdata, 0);
      rst = 1'b0;
      wait_clk(10);

      $display("[TB] single write C0 30 0A 5A");
      we_base = we_cnt;
      i2c_start();
      ack_or = 1'b0;
      write_byte(8'hC0, 8'h00, ack); ack_or |= ack;
      checkOutput("t1_busy_on", busy, 1);
      write_byte(8'h30, 8'h00, ack); ack_or |= ack;
      write_byte(8'h0A, 8'h00, ack); ack_or |= ack;
      write_byte(8'h5A, 8'h00, ack); ack_or |= ack;
      checkOutput("t1_acks", ack_or, 0);
      i2c_stop();
      wait_clk(20);
      checkOutput("t1_busy_off", busy, 0);
      checkOutput("t1_we_count", we_cnt - we_base, 1);
      checkOutput("t1_we_addr", we_addr_log[we_base], 16'h300A);
      checkOutput("t1_we_data", we_data_log[we_base], 8'h5A);
      checkOutput("t1_ptr", reg_addr, 16'h300B);

      $display("[TB] wrapping write at FFFF");
      we_base = we_cnt;
      i2c_start();
      ack_or = 1'b0;
      write_byte(8'hC0, 8'h00, ack); ack_or |= ack;
      write_byte(8'hFF, 8'h00, ack); ack_or |= ack;
      write_byte(8'hFF, 8'h00, ack); ack_or |= ack;
      write_byte(8'h11, 8'h00, ack); ack_or |= ack;
      write_byte(8'h22, 8'h00, ack); ack_or |= ack;
      i2c_stop();
      wait_clk(20);
      checkOutput("t2_acks", ack_or, 0);
      checkOutput("t2_we_count", we_cnt - we_base, 2);
      checkOutput("t2_we0_addr", we_addr_log[we_base], 16'hFFFF);
      checkOutput("t2_we0_data", we_data_log[we_base], 8'h11);
      checkOutput("t2_we1_addr", we_addr_log[we_base+1], 16'h0000);
      checkOutput("t2_we1_data", we_data_log[we_base+1], 8'h22);
      checkOutput("t2_ptr", reg_addr, 16'h0001);

      $display("[TB] pointer write, repeated start, two-byte read");
      we_base = we_cnt;
      re_base = re_cnt;
      i2c_start();
      ack_or = 1'b0;
      write_byte(8'hC0, 8'h00, ack); ack_or |= ack;
      write_byte(8'h30, 8'h00, ack); ack_or |= ack;
      write_byte(8'h0A, 8'h00, ack); ack_or |= ack;
      i2c_start();
      write_byte(8'hC1, 8'h00, ack); ack_or |= ack;
      checkOutput("t3_acks", ack_or, 0);
      read_byte(1'b0, rd);
      checkOutput("t3_rd0", rd, 8'hA5);
      read_byte(1'b1, rd);
      checkOutput("t3_rd1", rd, 8'h3C);
      i2c_stop();
      wait_clk(20);
      checkOutput("t3_re_count", re_cnt - re_base, 2);
      checkOutput("t3_re0_addr", re_addr_log[re_base], 16'h300A);
      checkOutput("t3_re1_addr", re_addr_log[re_base+1], 16'h300B);
      checkOutput("t3_we_count", we_cnt - we_base, 0);
      checkOutput("t3_ptr", reg_addr, 16'h300C);

      $display("[TB] address mismatch C2");
      we_base = we_cnt;
      re_base = re_cnt;
      oe_base = oe_cyc;
      i2c_start();
      write_byte(8'hC2, 8'h00, ack);
      checkOutput("t4_dev_nack", ack, 1);
      checkOutput("t4_busy", busy, 0);
      write_byte(8'h55, 8'h00, ack);
      checkOutput("t4_data_nack", ack, 1);
      i2c_stop();
      wait_clk(20);
      checkOutput("t4_oe_cycles", oe_cyc - oe_base, 0);
      checkOutput("t4_we_count", we_cnt - we_base, 0);
      checkOutput("t4_re_count", re_cnt - re_base, 0);

      $display("[TB] glitches on SDA while SCL high");
      we_base = we_cnt;
      i2c_start();
      ack_or = 1'b0;
      write_byte(8'hC0, 8'h00, ack); ack_or |= ack;
      write_byte(8'h12, 8'h00, ack); ack_or |= ack;
      write_byte(8'h34, 8'hFF, ack); ack_or |= ack;
      write_byte(8'h77, 8'hFF, ack); ack_or |= ack;
      i2c_stop();
      wait_clk(20);
      checkOutput("t5_acks", ack_or, 0);
      checkOutput("t5_we_count", we_cnt - we_base, 1);
      checkOutput("t5_we_addr", we_addr_log[we_base], 16'h1234);
      checkOutput("t5_we_data", we_data_log[we_base], 8'h77);

      $display("[TB] reset during read while driving 0");
      re_base = re_cnt;
      i2c_start();
      write_byte(8'hC1, 8'h00, ack);
      checkOutput("t6_dev_ack", ack, 0);
      checkOutput("t6_drive0", sda_oe, 1);
      checkOutput("t6_re_count", re_cnt - re_base, 1);
      checkOutput("t6_re_addr", re_addr_log[re_base], 16'h1235);
      we_base = we_cnt;
      re_base = re_cnt;
      @(posedge clk);
      #5 rst = 1'b1;
      #1;
      checkOutput("t6_oe_async", sda_oe, 0);
      wait_clk(3);
      checkOutput("t6_busy_rst", busy, 0);
      rst = 1'b0;
      scl_m = 1'b1;
      sda_m = 1'b1;
      wait_clk(2 * Q);
      checkOutput("t6_no_strobes", (we_cnt - we_base) + (re_cnt - re_base), 0);
      i2c_start();
      ack_or = 1'b0;
      write_byte(8'hC0, 8'h00, ack); ack_or |= ack;
      write_byte(8'h56, 8'h00, ack); ack_or |= ack;
      write_byte(8'h78, 8'h00, ack); ack_or |= ack;
      write_byte(8'h9A, 8'h00, ack); ack_or |= ack;
      i2c_stop();
      wait_clk(20);
      checkOutput("t6_acks", ack_or, 0);
      checkOutput("t6_we_count", we_cnt - we_base, 1);
      checkOutput("t6_we_addr", we_addr_log[we_base], 16'h5678);
      checkOutput("t6_we_data", we_data_log[we_base], 8'h9A);

      checkOutput("we_re_overlap", both_cnt, 0);
      checkOutput("sda_out_tied", sda_out, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
